// File: rtl/stage_fetch0_bp.sv
// Fetch-address stage: next-PC selection with a direct-mapped, ASID-tagged BTB
// and 2-bit taken counters. Prediction is combinational on the issued address.
module stage_fetch0_bp #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [29:0] RESET_PC    = 30'h0
) (
    input  logic        clk_core,
    input  logic        reset_n,
    output logic        fe0_valid,
    input  logic        fe1_stall,
    output logic        fe0_read_req,
    output logic [8:0]  fe0_read_asid,
    output logic [29:0] fe0_read_addr,
    output logic        fe0_pred_taken,
    output logic [29:0] fe0_pred_target,
    input  logic        de_setpc,
    input  logic [29:0] de_newpc,
    input  logic        de_btb_upd,
    input  logic [29:0] de_btb_pc,
    input  logic [29:0] de_btb_target,
    input  logic        de_btb_taken,
    input  logic        csr_fe_inhibit,
    input  logic        csr_setpc,
    input  logic [29:0] csr_newpc,
    input  logic [31:0] csr_satp,
    input  logic        csr_btb_flush
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [8:0]             btb_asid   [BTB_ENTRIES];
    logic [29:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [29:0]     fe0_pc;
    logic [8:0]      cur_asid;
    logic            satp_unused;
    logic [IDXW-1:0] rd_idx;
    logic [TAGW-1:0] rd_tag;
    logic            rd_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign cur_asid      = csr_satp[30:22];
    assign satp_unused   = ^{csr_satp[31], csr_satp[21:0]};
    assign fe0_read_asid = cur_asid;

    // A CSR redirect bypasses a fetch1 stall; inhibit overrides everything.
    assign fe0_read_req  = reset_n & (~fe1_stall | csr_setpc) & ~csr_fe_inhibit;
    assign fe0_valid     = fe0_read_req;
    assign fe0_read_addr = csr_setpc ? csr_newpc : (de_setpc ? de_newpc : fe0_pc);

    assign rd_idx = fe0_read_addr[IDXW-1:0];
    assign rd_tag = fe0_read_addr[29:IDXW];
    assign rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag)
                    && (btb_asid[rd_idx] == cur_asid);

    assign fe0_pred_taken  = rd_hit & btb_ctr[rd_idx][1];
    assign fe0_pred_target = btb_target[rd_idx];

    assign up_idx = de_btb_pc[IDXW-1:0];
    assign up_tag = de_btb_pc[29:IDXW];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag)
                    && (btb_asid[up_idx] == cur_asid);

    // An unissued redirect is parked in fe0_pc so it is replayed next cycle.
    always_ff @(posedge clk_core) begin
        if (!reset_n)
            fe0_pc <= RESET_PC;
        else if (fe0_read_req)
            fe0_pc <= fe0_pred_taken ? fe0_pred_target : fe0_read_addr + 30'd1;
        else if (csr_setpc || de_setpc)
            fe0_pc <= fe0_read_addr;
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n || csr_btb_flush)
            btb_valid <= '0;
        else if (de_btb_upd && (up_hit || de_btb_taken))
            btb_valid[up_idx] <= 1'b1;
    end

    // Entry payload carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk_core) begin
        if (de_btb_upd && !csr_btb_flush) begin
            if (up_hit) begin
                btb_ctr[up_idx] <= ctr_sat(btb_ctr[up_idx], de_btb_taken);
                if (de_btb_taken)
                    btb_target[up_idx] <= de_btb_target;
            end else if (de_btb_taken) begin
                btb_tag[up_idx]    <= up_tag;
                btb_asid[up_idx]   <= cur_asid;
                btb_target[up_idx] <= de_btb_target;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_stage_fetch0_bp.sv
// Bench for stage_fetch0_bp: directed scenarios then random traffic, all checked
// against a table-based BTB/next-PC model.
module tb_stage_fetch0_bp;

    localparam int          N     = 16;
    localparam int unsigned RST_A = 0;

    logic        clk_core;
    logic        reset_n;
    logic        fe0_valid;
    logic        fe1_stall;
    logic        fe0_read_req;
    logic [8:0]  fe0_read_asid;
    logic [29:0] fe0_read_addr;
    logic        fe0_pred_taken;
    logic [29:0] fe0_pred_target;
    logic        de_setpc;
    logic [29:0] de_newpc;
    logic        de_btb_upd;
    logic [29:0] de_btb_pc;
    logic [29:0] de_btb_target;
    logic        de_btb_taken;
    logic        csr_fe_inhibit;
    logic        csr_setpc;
    logic [29:0] csr_newpc;
    logic [31:0] csr_satp;
    logic        csr_btb_flush;

    stage_fetch0_bp dut (
        .clk_core(clk_core), .reset_n(reset_n), .fe0_valid(fe0_valid),
        .fe1_stall(fe1_stall), .fe0_read_req(fe0_read_req),
        .fe0_read_asid(fe0_read_asid), .fe0_read_addr(fe0_read_addr),
        .fe0_pred_taken(fe0_pred_taken), .fe0_pred_target(fe0_pred_target),
        .de_setpc(de_setpc), .de_newpc(de_newpc), .de_btb_upd(de_btb_upd),
        .de_btb_pc(de_btb_pc), .de_btb_target(de_btb_target),
        .de_btb_taken(de_btb_taken), .csr_fe_inhibit(csr_fe_inhibit),
        .csr_setpc(csr_setpc), .csr_newpc(csr_newpc), .csr_satp(csr_satp),
        .csr_btb_flush(csr_btb_flush)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    int checks = 0;
    int errors = 0;

    // Reference state: BTB as plain tables keyed by addr % N, tag = addr / N.
    int unsigned m_pc;
    bit          m_vld  [N];
    int unsigned m_tag  [N];
    int unsigned m_asid [N];
    int unsigned m_tgt  [N];
    int          m_ctr  [N];

    bit          e_req, e_pt;
    int unsigned e_addr, e_tgt, e_asid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        int unsigned i;
        e_asid = (csr_satp >> 22) & 32'h1FF;
        e_req  = reset_n && (!fe1_stall || csr_setpc) && !csr_fe_inhibit;
        e_addr = csr_setpc ? csr_newpc : (de_setpc ? de_newpc : m_pc);
        i      = e_addr % N;
        e_pt   = m_vld[i] && (m_tag[i] == e_addr / N) && (m_asid[i] == e_asid)
                 && (m_ctr[i] >= 2);
        e_tgt  = m_tgt[i];
        #1;
        chk("req", {31'b0, fe0_read_req}, {31'b0, e_req});
        chk("valid", {31'b0, fe0_valid}, {31'b0, e_req});
        if (reset_n) begin
            chk("asid", {23'b0, fe0_read_asid}, e_asid);
            chk("addr", {2'b0, fe0_read_addr}, e_addr);
            chk("pred_taken", {31'b0, fe0_pred_taken}, {31'b0, e_pt});
            if (e_pt)
                chk("pred_target", {2'b0, fe0_pred_target}, e_tgt);
        end
    endtask

    task automatic advance();
        int unsigned j, t;
        bit hit;
        if (!reset_n) begin
            m_pc = RST_A;
            for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
        end else begin
            if (e_req)
                m_pc = e_pt ? e_tgt : ((e_addr + 1) & 32'h3FFF_FFFF);
            else if (csr_setpc || de_setpc)
                m_pc = e_addr;
            if (csr_btb_flush) begin
                for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
            end else if (de_btb_upd) begin
                j   = de_btb_pc % N;
                t   = de_btb_pc / N;
                hit = m_vld[j] && (m_tag[j] == t) && (m_asid[j] == e_asid);
                if (hit) begin
                    if (de_btb_taken) begin
                        m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                        m_tgt[j] = de_btb_target;
                    end else begin
                        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                    end
                end else if (de_btb_taken) begin
                    m_vld[j]  = 1'b1;
                    m_tag[j]  = t;
                    m_asid[j] = e_asid;
                    m_tgt[j]  = de_btb_target;
                    m_ctr[j]  = 2;
                end
            end
        end
        @(negedge clk_core);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic redirect(input logic [29:0] a);
        de_setpc = 1'b1;
        de_newpc = a;
    endtask

    task automatic train(input logic [29:0] pc, input logic [29:0] tgt, input logic tk);
        de_btb_upd    = 1'b1;
        de_btb_pc     = pc;
        de_btb_target = tgt;
        de_btb_taken  = tk;
    endtask

    initial begin
        reset_n = 1'b0; fe1_stall = 1'b0; csr_fe_inhibit = 1'b0;
        de_setpc = 1'b0; de_newpc = '0; de_btb_upd = 1'b0; de_btb_pc = '0;
        de_btb_target = '0; de_btb_taken = 1'b0; csr_setpc = 1'b0;
        csr_newpc = '0; csr_btb_flush = 1'b0;
        csr_satp = {1'b0, 9'd5, 22'h0};
        m_pc = 0;
        @(negedge clk_core);
        step();
        settle(); chk("rst_req", {31'b0, fe0_read_req}, 32'd0); advance();

        // Sequential fetch from RESET_PC with an empty BTB
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("seq_addr", {2'b0, fe0_read_addr}, k);
            chk("seq_pt", {31'b0, fe0_pred_taken}, 32'd0);
            advance();
        end

        // Allocate 0x10 -> 0x40, then approach from 0x0F
        train(30'h10, 30'h40, 1'b1); step(); de_btb_upd = 1'b0;
        redirect(30'h0F); step(); de_setpc = 1'b0;
        settle();
        chk("alloc_addr", {2'b0, fe0_read_addr}, 32'h10);
        chk("alloc_pt", {31'b0, fe0_pred_taken}, 32'd1);
        chk("alloc_tgt", {2'b0, fe0_pred_target}, 32'h40);
        advance();
        settle(); chk("follow_tgt", {2'b0, fe0_read_addr}, 32'h40); advance();

        // Two not-taken updates drop the counter to 0
        train(30'h10, 30'h40, 1'b0); step(); step(); de_btb_upd = 1'b0;
        redirect(30'h10);
        settle(); chk("nt_pt", {31'b0, fe0_pred_taken}, 32'd0); advance();
        de_setpc = 1'b0;
        settle(); chk("nt_next", {2'b0, fe0_read_addr}, 32'h11); advance();

        // Four taken updates saturate at 3; one not-taken still predicts taken
        train(30'h10, 30'h40, 1'b1); step(); step(); step(); step();
        de_btb_taken = 1'b0; step(); de_btb_upd = 1'b0;
        redirect(30'h10);
        settle(); chk("sat_pt", {31'b0, fe0_pred_taken}, 32'd1); advance();
        de_setpc = 1'b0;

        // Decode redirect held across a stall
        fe1_stall = 1'b1; redirect(30'h200);
        settle(); chk("stall_req", {31'b0, fe0_read_req}, 32'd0); advance();
        fe1_stall = 1'b0; de_setpc = 1'b0;
        settle(); chk("held_redir", {2'b0, fe0_read_addr}, 32'h200); advance();

        // CSR beats decode and issues through a stall
        fe1_stall = 1'b1; redirect(30'h123); csr_setpc = 1'b1; csr_newpc = 30'h300;
        settle();
        chk("csr_req", {31'b0, fe0_read_req}, 32'd1);
        chk("csr_addr", {2'b0, fe0_read_addr}, 32'h300);
        advance();
        fe1_stall = 1'b0; de_setpc = 1'b0; csr_setpc = 1'b0;
        step();

        // Aliasing: other tag, other ASID, then flush beats a same-cycle update
        redirect(30'h20);
        settle(); chk("alias_tag", {31'b0, fe0_pred_taken}, 32'd0); advance();
        csr_satp = {1'b0, 9'd6, 22'h0}; redirect(30'h10);
        settle(); chk("alias_asid", {31'b0, fe0_pred_taken}, 32'd0); advance();
        csr_satp = {1'b0, 9'd5, 22'h0};
        settle(); chk("asid_back", {31'b0, fe0_pred_taken}, 32'd1); advance();
        de_setpc = 1'b0; csr_btb_flush = 1'b1; train(30'h35, 30'h7, 1'b1); step();
        csr_btb_flush = 1'b0; de_btb_upd = 1'b0;
        redirect(30'h10);
        settle(); chk("flush_old", {31'b0, fe0_pred_taken}, 32'd0); advance();
        redirect(30'h35);
        settle(); chk("flush_drop", {31'b0, fe0_pred_taken}, 32'd0); advance();

        // Lookup in the write cycle sees old contents
        redirect(30'h50); train(30'h50, 30'h99, 1'b1);
        settle(); chk("rw_old", {31'b0, fe0_pred_taken}, 32'd0); advance();
        de_btb_upd = 1'b0;
        settle(); chk("rw_new", {2'b0, fe0_pred_target}, 32'h99); advance();
        de_setpc = 1'b0;

        // Inhibit holds the PC
        csr_fe_inhibit = 1'b1;
        settle(); chk("inh_req", {31'b0, fe0_read_req}, 32'd0); advance();
        settle(); chk("inh_hold", {2'b0, fe0_read_addr}, 32'h99); advance();
        csr_fe_inhibit = 1'b0;

        // 30-bit wrap
        redirect(30'h3FFF_FFFF); step(); de_setpc = 1'b0;
        settle(); chk("wrap", {2'b0, fe0_read_addr}, 32'h0); advance();

        // Reset discards a parked redirect
        fe1_stall = 1'b1; redirect(30'h222); step();
        reset_n = 1'b0; de_setpc = 1'b0; step();
        reset_n = 1'b1; fe1_stall = 1'b0;
        settle();
        chk("mid_rst_addr", {2'b0, fe0_read_addr}, 32'h0);
        chk("mid_rst_pt", {31'b0, fe0_pred_taken}, 32'd0);
        advance();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset_n        = ($urandom_range(0, 99) != 0);
            fe1_stall      = ($urandom_range(0, 3) == 0);
            csr_fe_inhibit = ($urandom_range(0, 9) == 0);
            de_setpc       = ($urandom_range(0, 9) == 0);
            de_newpc       = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF
                                                          : 30'($urandom_range(0, 63));
            csr_setpc      = ($urandom_range(0, 19) == 0);
            csr_newpc      = 30'($urandom_range(0, 63));
            de_btb_upd     = ($urandom_range(0, 9) < 3);
            de_btb_pc      = 30'($urandom_range(0, 63));
            de_btb_target  = 30'($urandom_range(0, 63));
            de_btb_taken   = ($urandom_range(0, 2) != 0);
            csr_btb_flush  = ($urandom_range(0, 39) == 0);
            csr_satp       = {1'b0, ($urandom_range(0, 3) == 0) ? 9'd6 : 9'd5,
                              22'($urandom)};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
